// File: rtl/reg_file_if.sv
// Register-file port bundle: operand read request/response and writeback.
// master drives requests (decode/writeback side); slave is the register file.
interface reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              rd_en;
  logic [ADDR_W-1:0] rs1_addr;
  logic [ADDR_W-1:0] rs2_addr;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] arg1;
  logic [DATA_W-1:0] arg2;
  logic              rd_valid;

  modport master (
    output rd_en, rs1_addr, rs2_addr, wr_en, wr_addr, wr_data,
    input  arg1, arg2, rd_valid
  );

  modport slave (
    input  rd_en, rs1_addr, rs2_addr, wr_en, wr_addr, wr_data,
    output arg1, arg2, rd_valid
  );
endinterface

// File: rtl/reg_file.sv
// 2**ADDR_W x DATA_W register file, r0 hardwired to zero, two registered read lanes.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to a matching read.

// One read lane: selects a register (or the forwarded write) and holds it as an operand.
module reg_file_rd_lane #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 rd_en,
  input  logic [ADDR_W-1:0]                    addr,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]   regs,
  input  logic                                 fwd_hit,
  input  logic [DATA_W-1:0]                    fwd_data,
  output logic [DATA_W-1:0]                    arg
);
  logic [DATA_W-1:0] rd_data;

  always_comb begin
    rd_data = regs[addr];
    if (fwd_hit) rd_data = fwd_data;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     arg <= '0;
    else if (rd_en) arg <= rd_data;
endmodule

module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  reg_file_if.slave  bus
);
  localparam int NUM_REGS  = 2**ADDR_W;
  localparam int NUM_LANES = 2;
  localparam int STAGES    = 1;

  logic [NUM_REGS-1:0][DATA_W-1:0]  regs;
  logic [NUM_LANES-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_LANES-1:0][DATA_W-1:0] args;
  logic [NUM_LANES-1:0]             fwd_hit;
  logic [STAGES:1]                  vld_q;
  logic [STAGES:0]                  vld_pipe;

  assign rd_addr = {bus.rs2_addr, bus.rs1_addr};

  // r0 is never written, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      regs <= '0;
    else if (bus.wr_en && (bus.wr_addr != '0))
      regs[bus.wr_addr] <= bus.wr_data;

  genvar l;
  generate
    for (l = 0; l < NUM_LANES; l++) begin : g_lane
`ifdef REG_FILE_BYPASS_EN
      assign fwd_hit[l] = bus.wr_en && (bus.wr_addr == rd_addr[l]) && (rd_addr[l] != '0);
`else
      assign fwd_hit[l] = 1'b0;
`endif
      reg_file_rd_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_lane (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_en    (bus.rd_en),
        .addr     (rd_addr[l]),
        .regs     (regs),
        .fwd_hit  (fwd_hit[l]),
        .fwd_data (bus.wr_data),
        .arg      (args[l])
      );
    end
  endgenerate

  // vld_pipe[0] is the live request; vld_pipe[STAGES] lines up with the operand registers.
  assign vld_pipe = {vld_q, bus.rd_en};

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_pipe[STAGES-1:0];

  assign bus.arg1     = args[0];
  assign bus.arg2     = args[1];
  assign bus.rd_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_reg_file.sv
// Randomized + directed check of reg_file against an array-based register model.
// Honours REG_FILE_BYPASS_EN for same-cycle read-after-write expectations.
module tb_reg_file;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  reg_file #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] mdl [32];
  logic [DW-1:0] exp1, exp2;
  logic          expv;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_arg1"}, bus.arg1, exp1);
    chk({tag, "_arg2"}, bus.arg2, exp2);
    chk({tag, "_vld"}, DW'(bus.rd_valid), DW'(expv));
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    exp1 = '0; exp2 = '0; expv = 1'b0;
  endtask

  function automatic logic [DW-1:0] mdl_read(input int a, input logic wr, input int wa,
                                             input logic [DW-1:0] wd);
    if (a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (wr && wa == a) return wd;
`endif
    return mdl[a];
  endfunction

  // One clock: drive request, let the edge happen, advance the model, compare.
  task automatic cycle(input string tag, input logic rd, input int a1, input int a2,
                       input logic wr, input int wa, input logic [DW-1:0] wd);
    bus.rd_en = rd; bus.rs1_addr = AW'(a1); bus.rs2_addr = AW'(a2);
    bus.wr_en = wr; bus.wr_addr = AW'(wa); bus.wr_data = wd;
    @(posedge clk);
    #1;
    if (rd) begin
      exp1 = mdl_read(a1, wr, wa, wd);
      exp2 = mdl_read(a2, wr, wa, wd);
    end
    expv = rd;
    if (wr && wa != 0) mdl[wa] = wd;
    chk_outs(tag);
  endtask

  task automatic rand_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      int wa, a1, a2;
      wa = $urandom_range(0, 31);
      a1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 31);
      a2 = ($urandom_range(0, 3) == 0) ? a1 : $urandom_range(0, 31);
      cycle("rand", 1'($urandom), a1, a2, 1'($urandom), wa, $urandom);
    end
  endtask

  initial begin
    bus.rd_en = 0; bus.rs1_addr = '0; bus.rs2_addr = '0;
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    mdl_reset();
    #3;
    chk_outs("por");
    #9 rst_n = 1'b1;

    for (int i = 0; i < 16; i++) cycle("rst_all", 1'b1, 2*i, 2*i+1, 1'b0, 0, '0);

    cycle("wr_r1", 1'b0, 0, 0, 1'b1, 1, 32'h4e0f92be);
    cycle("wr_r2", 1'b0, 0, 0, 1'b1, 2, 32'h080011F3);
    cycle("rd_r1r2", 1'b1, 1, 2, 1'b0, 0, '0);
    chk("rd_r1r2_lit", bus.arg1, 32'h4e0f92be);

    cycle("wr_r0", 1'b0, 0, 0, 1'b1, 0, 32'h1234fedc);
    cycle("rd_r0", 1'b1, 0, 0, 1'b0, 0, '0);

    cycle("wr_r5_old", 1'b0, 0, 0, 1'b1, 5, 32'h11110000);
    cycle("raw_r5", 1'b1, 5, 1, 1'b1, 5, 32'h00742069);
`ifdef REG_FILE_BYPASS_EN
    chk("raw_r5_lit", bus.arg1, 32'h00742069);
`else
    chk("raw_r5_lit", bus.arg1, 32'h11110000);
`endif
    cycle("rd_r5", 1'b1, 5, 5, 1'b0, 0, '0);
    chk("rd_r5_lit", bus.arg1, 32'h00742069);

    cycle("b2b_0", 1'b1, 1, 2, 1'b0, 0, '0);
    cycle("b2b_1", 1'b1, 2, 5, 1'b0, 0, '0);
    cycle("b2b_2", 1'b1, 5, 1, 1'b0, 0, '0);
    cycle("b2b_hold0", 1'b0, 2, 2, 1'b0, 0, '0);
    cycle("b2b_hold1", 1'b0, 0, 0, 1'b0, 0, '0);

    cycle("wr_r31", 1'b0, 0, 0, 1'b1, 31, 32'h00000001);
    cycle("rd_r31", 1'b1, 31, 31, 1'b0, 0, '0);

    rand_cycles(300);

    // Async reset between edges with a read and write pending.
    cycle("pre_rst", 1'b1, 1, 2, 1'b0, 0, '0);
    bus.rd_en = 1; bus.rs1_addr = 5'd7; bus.rs2_addr = 5'd1;
    bus.wr_en = 1; bus.wr_addr = 5'd7; bus.wr_data = 32'hdeadbeef;
    #2 rst_n = 1'b0;
    #1;
    mdl_reset();
    chk_outs("async_rst");
    @(posedge clk);
    #1;
    chk_outs("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("post_rst", 1'b1, 7, 1, 1'b0, 0, '0);
    for (int i = 0; i < 16; i++) cycle("post_rst_all", 1'b1, 31-i, i, 1'b0, 0, '0);

    rand_cycles(100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register and operand width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register address width; register count is 2**ADDR_W (32).
REQ-003 Port clk, input, 1, SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port rst_n, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-005 Port rd_en, input, 1, SHALL request an operand read this cycle.
REQ-006 Port rs1_addr, input, ADDR_W, SHALL select the register driven onto arg1.
REQ-007 Port rs2_addr, input, ADDR_W, SHALL select the register driven onto arg2.
REQ-008 Port wr_en, input, 1, SHALL request a register write this cycle.
REQ-009 Port wr_addr, input, ADDR_W, SHALL select the destination register.
REQ-010 Port wr_data, input, DATA_W, SHALL carry write data (ALU_result writeback).
REQ-011 Port arg1, output, DATA_W, SHALL be the registered operand A feeding the ALU arg1 input.
REQ-012 Port arg2, output, DATA_W, SHALL be the registered operand B feeding the ALU arg2 input.
REQ-013 Port rd_valid, output, 1, SHALL be high for exactly the cycles in which arg1/arg2 hold data captured by an rd_en on the previous edge.

Function
REQ-014 Read latency SHALL be one cycle: rd_en sampled high at edge N loads arg1/arg2 at edge N; rd_valid high from edge N to edge N+1.
REQ-015 With rd_en low at an edge, arg1/arg2 SHALL hold their previous values and rd_valid SHALL go low.
REQ-016 Back-to-back rd_en SHALL be accepted every cycle with no bubbles; rd_valid stays high throughout.
REQ-017 A write with wr_en high at an edge SHALL update register wr_addr with wr_data at that edge.
REQ-018 Register 0 SHALL always read as zero; writes to address 0 SHALL be discarded.
REQ-019 Reads and writes SHALL be independent; a read and a write in the same cycle SHALL both complete.
REQ-020 Same-cycle read and write to the same non-zero address SHALL return the value defined in REQ-025/REQ-026.
REQ-021 rs1_addr equal to rs2_addr SHALL drive identical values on arg1 and arg2.
REQ-022 No X SHALL propagate to arg1/arg2 from unwritten registers; all registers hold defined values after reset.

Reset
REQ-023 On rst_n low, all 2**ADDR_W registers, arg1, arg2 and rd_valid SHALL clear to 0 immediately, independent of clk.
REQ-024 Reset asserted mid-operation SHALL abort any same-cycle read or write; the first edge with rst_n high SHALL behave as normal operation.

Configuration
REQ-025 With macro REG_FILE_BYPASS_EN defined, a same-cycle read of a non-zero address being written SHALL return wr_data (write-to-read forwarding).
REQ-026 Without REG_FILE_BYPASS_EN, that read SHALL return the register's old value; the write still completes.

Verification
REQ-027 Reset: assert rst_n=0 between edges -> arg1=arg2=0, rd_valid=0 immediately; afterwards read all 32 addresses -> all 0.
REQ-028 Write 32'h4e0f92be to r1, 32'h080011F3 to r2, then rd_en with rs1=1, rs2=2 -> next cycle arg1=32'h4e0f92be, arg2=32'h080011F3, rd_valid=1.
REQ-029 Write 32'h1234fedc to r0, then read rs1=0, rs2=0 -> arg1=arg2=32'h00000000.
REQ-030 Same cycle wr_en to r5 with 32'h00742069 and rd_en rs1=5 (r5 previously 32'h11110000) -> arg1=32'h00742069 with REG_FILE_BYPASS_EN, 32'h11110000 without; following read returns 32'h00742069 in both builds.
REQ-031 rd_en high 3 cycles then low -> rd_valid high 3 cycles then low; arg1/arg2 hold the third read's values.
REQ-032 Write r31=32'h00000001, then rd_en rs1=31, rs2=31 -> arg1=arg2=32'h00000001.
